word_unstacker: RTL and testbench

WORD_UNSTACKER -- requirements
Module: word_unstacker

---
 rtl/word_unstacker.sv | 133 +++++++++++++
 tb/tb_word_unstacker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_unstacker.sv
// word_unstacker: splits each IN_W-bit input word into N = IN_W/OUT_W slices of OUT_W bits.
// Define WORD_UNSTACKER_PREFETCH_EN for a two-entry buffer that streams slices across word boundaries.
module word_unstacker #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             enable_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [IN_W-1:0]  in_data_i,
   input  logic             msb_first_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o,
   output logic             out_last_o,
   output logic             busy_o
);

   localparam int N  = IN_W / OUT_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   if (((IN_W % OUT_W) != 0) || (N < 2)) begin : g_bad_params
      $error("word_unstacker: IN_W must be an integer multiple (>= 2) of OUT_W");
   end

   typedef struct packed {
      logic [IN_W-1:0] data;
      logic            msb_first;
      logic [CW-1:0]   cnt;
   } entry_t;

   entry_t                  head_q;
   logic                    head_valid_q;
   logic                    alive_q;
   entry_t                  new_entry;
   logic                    in_fire;
   logic                    out_fire;
   logic                    head_at_last;
   logic                    head_done;
   logic [CW-1:0]           slice_idx;
   logic [N-1:0][OUT_W-1:0] slices;

   assign new_entry    = '{data: in_data_i, msb_first: msb_first_i, cnt: '0};
   assign out_valid_o  = enable_i & head_valid_q;
   assign out_fire     = out_valid_o & out_ready_i;
   assign in_fire      = in_valid_i & in_ready_o;
   assign head_at_last = (head_q.cnt == LAST_CNT);
   assign head_done    = out_fire & head_at_last;

   // Slice k of an msb-first word is the (N-1-k)th OUT_W chunk counted from bit 0.
   assign slices      = head_q.data;
   assign slice_idx   = head_q.msb_first ? (LAST_CNT - head_q.cnt) : head_q.cnt;
   assign out_data_o  = out_valid_o ? slices[slice_idx] : '0;
   assign out_last_o  = out_valid_o & head_at_last;
   assign busy_o      = head_valid_q;

`ifdef WORD_UNSTACKER_PREFETCH_EN
   entry_t tail_q;
   logic   tail_valid_q;

   assign in_ready_o = enable_i & alive_q & ~(head_valid_q & tail_valid_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q       <= '0;
         head_valid_q <= 1'b0;
         tail_q       <= '0;
         tail_valid_q <= 1'b0;
         alive_q      <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (clr_i) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
            tail_q       <= '0;
            tail_valid_q <= 1'b0;
         end else if (head_done) begin
            // The finished word leaves; the queued word, or one arriving now, takes its place.
            if (tail_valid_q) begin
               head_q       <= tail_q;
               tail_q       <= in_fire ? new_entry : '0;
               tail_valid_q <= in_fire;
            end else begin
               head_q       <= in_fire ? new_entry : '0;
               head_valid_q <= in_fire;
            end
         end else begin
            if (out_fire) begin
               head_q.cnt <= head_q.cnt + 1'b1;
            end
            if (in_fire) begin
               if (head_valid_q) begin
                  tail_q       <= new_entry;
                  tail_valid_q <= 1'b1;
               end else begin
                  head_q       <= new_entry;
                  head_valid_q <= 1'b1;
               end
            end
         end
      end
   end
`else
   assign in_ready_o = enable_i & alive_q & ~head_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q       <= '0;
         head_valid_q <= 1'b0;
         alive_q      <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (clr_i) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
         end else if (head_done) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
         end else if (out_fire) begin
            head_q.cnt <= head_q.cnt + 1'b1;
         end else if (in_fire) begin
            head_q       <= new_entry;
            head_valid_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_word_unstacker.sv
// Self-checking bench for word_unstacker: table vectors, directed corner cases and a randomized
// run against a slice-queue reference model; adapts to WORD_UNSTACKER_PREFETCH_EN.
module tb_word_unstacker;

   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int N     = IN_W / OUT_W;
`ifdef WORD_UNSTACKER_PREFETCH_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             clr_i, enable_i, in_valid_i, msb_first_i, out_ready_i;
   logic [IN_W-1:0]  in_data_i;
   logic             in_ready_o, out_valid_o, out_last_o, busy_o;
   logic [OUT_W-1:0] out_data_o;

   logic             s_clr, s_enable, s_in_valid, s_msb_first, s_out_ready;
   logic [63:0]      s_in_data;
   logic             s_in_ready, s_out_valid, s_out_last, s_busy;
   logic [15:0]      s_out_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic             msb;
      logic [IN_W-1:0]  word;
      logic [OUT_W-1:0] exp [4];
   } vec_t;
   vec_t vecs [4];

   always #5 clk_i = ~clk_i;

   word_unstacker #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .msb_first_i(msb_first_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o)
   );

   word_unstacker #(.IN_W(64), .OUT_W(16)) dut_small (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(s_clr), .enable_i(s_enable),
      .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
      .msb_first_i(s_msb_first), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
      .out_data_o(s_out_data), .out_last_o(s_out_last), .busy_o(s_busy)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_val(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives the word until the DUT takes it, then changes msb_first_i to show it is not re-sampled.
   task automatic apply_stimulus(input logic msb, input logic [IN_W-1:0] w);
      bit done = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = w;
      msb_first_i = msb;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         done = in_ready_o;
         tick();
      end
      check_val("accept", {31'b0, done}, 32'd1);
      in_valid_i  = 1'b0;
      msb_first_i = ~msb;
   endtask

   task automatic check_output(input string name, input logic [OUT_W-1:0] exp_data, input logic exp_last);
      #1;
      check_val({name, "_valid"}, {31'b0, out_valid_o}, 32'd1);
      check_val({name, "_data"}, out_data_o, exp_data);
      check_val({name, "_last"}, {31'b0, out_last_o}, {31'b0, exp_last});
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [IN_W-1:0]  w0, w1, tw [2];
      logic             tm [2];
      logic [OUT_W-1:0] got [$];
      int               first, lastc, widx;
      logic [OUT_W-1:0] sq [$];
      bit               lq [$];
      int               held;

      w0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      w1 = 128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF;
      vecs[0].msb = 1'b1; vecs[0].word = w0;
      vecs[0].exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      vecs[1].msb = 1'b0; vecs[1].word = w0;
      vecs[1].exp = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
      vecs[2].msb = 1'b1; vecs[2].word = w1;
      vecs[2].exp = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF};
      vecs[3].msb = 1'b0; vecs[3].word = 128'h80000000_00000000_00000000_00000001;
      vecs[3].exp = '{32'h00000001, 32'h00000000, 32'h00000000, 32'h80000000};

      rst_i = 1'b1; clr_i = 1'b0; enable_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0;
      msb_first_i = 1'b0; out_ready_i = 1'b0;
      s_clr = 1'b0; s_enable = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_msb_first = 1'b0;
      s_out_ready = 1'b0;

      tick();
      tick();
      #1;
      check_val("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
      check_val("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
      check_val("rst_busy", {31'b0, busy_o}, 32'd0);
      check_val("rst_out_data", out_data_o, 32'd0);
      check_val("rst_out_last", {31'b0, out_last_o}, 32'd0);
      rst_i = 1'b0;
      tick();
      tick();
      #1;
      check_val("post_rst_in_ready", {31'b0, in_ready_o}, 32'd1);
      check_val("post_rst_out_valid", {31'b0, out_valid_o}, 32'd0);

      out_ready_i = 1'b1;
      for (int v = 0; v < 4; v++) begin
         apply_stimulus(vecs[v].msb, vecs[v].word);
         for (int k = 0; k < N; k++)
            check_output($sformatf("vec%0d_s%0d", v, k), vecs[v].exp[k], k == N - 1);
         #1;
         check_val($sformatf("vec%0d_idle", v), {31'b0, out_valid_o}, 32'd0);
         check_val($sformatf("vec%0d_idle_data", v), out_data_o, 32'd0);
      end

      // Downstream stall on slice 1 for three cycles.
      apply_stimulus(1'b1, w0);
      check_output("stall_s0", 32'h00112233, 1'b0);
      out_ready_i = 1'b0;
      in_valid_i  = (CAP == 1);
      in_data_i   = w1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check_val($sformatf("stall%0d_valid", c), {31'b0, out_valid_o}, 32'd1);
         check_val($sformatf("stall%0d_data", c), out_data_o, 32'h44556677);
         check_val($sformatf("stall%0d_last", c), {31'b0, out_last_o}, 32'd0);
         check_val($sformatf("stall%0d_in_ready", c), {31'b0, in_ready_o}, (CAP > 1) ? 32'd1 : 32'd0);
         tick();
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      check_output("stall_s1", 32'h44556677, 1'b0);
      check_output("stall_s2", 32'h8899AABB, 1'b0);
      check_output("stall_s3", 32'hCCDDEEFF, 1'b1);

      // Clear after slice 1 discards the rest of the word.
      apply_stimulus(1'b1, w0);
      check_output("clr_s0", 32'h00112233, 1'b0);
      check_output("clr_s1", 32'h44556677, 1'b0);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      #1;
      check_val("clr_out_valid", {31'b0, out_valid_o}, 32'd0);
      check_val("clr_busy", {31'b0, busy_o}, 32'd0);
      check_val("clr_out_data", out_data_o, 32'd0);
      apply_stimulus(1'b0, w1);
      check_output("clr_next_s0", 32'hFFFFFFFF, 1'b0);
      check_output("clr_next_s1", 32'h89ABCDEF, 1'b0);
      check_output("clr_next_s2", 32'h01234567, 1'b0);
      check_output("clr_next_s3", 32'hDEADBEEF, 1'b1);

      // Two words back to back: count idle cycles between the first and last slice.
      tw[0] = w0; tm[0] = 1'b1;
      tw[1] = w1; tm[1] = 1'b0;
      widx = 0; first = -1; lastc = -1;
      for (int c = 0; c < 16; c++) begin
         bit acc;
         in_valid_i = (widx < 2);
         if (widx < 2) begin
            in_data_i   = tw[widx];
            msb_first_i = tm[widx];
         end
         #1;
         if (out_valid_o) begin
            got.push_back(out_data_o);
            if (first < 0) first = c;
            lastc = c;
         end
         acc = in_valid_i && in_ready_o;
         tick();
         if (acc) widx++;
      end
      in_valid_i = 1'b0;
      check_val("b2b_count", got.size(), 32'd8);
      check_val("b2b_gap", lastc - first + 1 - 8, (CAP == 2) ? 32'd0 : 32'd1);
      for (int k = 0; k < 8 && k < got.size(); k++)
         check_val($sformatf("b2b_s%0d", k), got[k], (k < 4) ? vecs[0].exp[k] : vecs[2].exp[7 - k]);

      // Narrow instance: enable dropped while slice 2 is presented.
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      s_in_data   = 64'h1111_2222_3333_4444;
      s_msb_first = 1'b1;
      #1;
      check_val("en_accept", {31'b0, s_in_ready}, 32'd1);
      tick();
      s_in_valid = 1'b0;
      #1;
      check_val("en_s0", {16'b0, s_out_data}, 32'h1111);
      tick();
      #1;
      check_val("en_s1", {16'b0, s_out_data}, 32'h2222);
      tick();
      s_enable = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         check_val($sformatf("en_low%0d_valid", c), {31'b0, s_out_valid}, 32'd0);
         check_val($sformatf("en_low%0d_data", c), {16'b0, s_out_data}, 32'd0);
         check_val($sformatf("en_low%0d_in_ready", c), {31'b0, s_in_ready}, 32'd0);
         check_val($sformatf("en_low%0d_busy", c), {31'b0, s_busy}, 32'd1);
         tick();
      end
      s_enable = 1'b1;
      #1;
      check_val("en_s2_valid", {31'b0, s_out_valid}, 32'd1);
      check_val("en_s2", {16'b0, s_out_data}, 32'h3333);
      check_val("en_s2_last", {31'b0, s_out_last}, 32'd0);
      tick();
      #1;
      check_val("en_s3", {16'b0, s_out_data}, 32'h4444);
      check_val("en_s3_last", {31'b0, s_out_last}, 32'd1);
      tick();
      #1;
      check_val("en_done_valid", {31'b0, s_out_valid}, 32'd0);

      // Randomized traffic against a queue of expected slices.
      held = 0;
      for (int c = 0; c < 3000; c++) begin
         bit exp_valid, exp_ready, out_fire, in_fire;
         logic [OUT_W-1:0] exp_data;
         enable_i    = ($urandom_range(0, 9) != 0);
         in_valid_i  = $urandom_range(0, 1);
         out_ready_i = ($urandom_range(0, 3) != 0);
         clr_i       = ($urandom_range(0, 99) == 0);
         msb_first_i = $urandom_range(0, 1);
         in_data_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
         #1;
         exp_valid = enable_i && (held > 0);
         exp_ready = enable_i && (held < CAP);
         exp_data  = exp_valid ? sq[0] : '0;
         check_val("rnd_valid", {31'b0, out_valid_o}, {31'b0, exp_valid});
         check_val("rnd_data", out_data_o, exp_data);
         check_val("rnd_last", {31'b0, out_last_o}, {31'b0, exp_valid && lq[0]});
         check_val("rnd_in_ready", {31'b0, in_ready_o}, {31'b0, exp_ready});
         check_val("rnd_busy", {31'b0, busy_o}, {31'b0, held > 0});
         if (clr_i) begin
            sq.delete();
            lq.delete();
            held = 0;
         end else begin
            out_fire = exp_valid && out_ready_i;
            in_fire  = exp_ready && in_valid_i;
            if (out_fire) begin
               if (lq[0]) held--;
               void'(sq.pop_front());
               void'(lq.pop_front());
            end
            if (in_fire) begin
               for (int k = 0; k < N; k++) begin
                  int idx;
                  logic [IN_W-1:0] sh;
                  idx = msb_first_i ? (N - 1 - k) : k;
                  sh  = in_data_i >> (idx * OUT_W);
                  sq.push_back(sh[OUT_W-1:0]);
                  lq.push_back(k == N - 1);
               end
               held++;
            end
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
